sdram_init_refresh_ctrl: RTL and testbench
==========================================

// Module: sdram_init_refresh_ctrl
// PURPOSE
//  Parametrised SDRAM power-up init sequencer plus periodic auto-refresh engine
//  for the W9825G6KH-class SDR SDRAM path. Drives the command bus until
//  SDRAM_INIT_DONE, then raises refresh requests to the bus arbiter. Once granted,
//  it issues PRECHARGE-ALL + AUTO REFRESH. Supports postponed refresh (up to 8 pending).
// PARAMETERS
//  CLK_FREQ_MHZ   100  REF_CLK frequency; T_POWERUP_CYC = CLK_FREQ_MHZ*T_POWERUP_US
//  T_POWERUP_US   200  power-up NOP wait, us
//  T_RP_CYC       2    PRECHARGE->next cmd, cycles (cmd cycle counts as 1)
//  T_RFC_CYC      7    AUTO REFRESH->next cmd, cycles
//  T_MRD_CYC      2    LOAD MODE->done/next cmd, cycles
//  INIT_REF_NUM   8    AUTO REFRESH count during init (>=2)
//  REF_PERIOD_CYC 780  refresh interval, cycles (7.8us @100MHz)
//  CAS_LAT        3    mode reg CL (2 or 3)
//  BL_CODE        3    mode reg burst-length code (3'b011 = BL8)
//  ROW_W          13   address width;  BANK_W 2  bank address width
// PORTS
//  REF_CLK          in   1       system clock, all logic on posedge
//  RST_N            in   1       async active-low reset
//  SDRAM_INIT_DONE  out  1       1 = init complete, sticky until reset
//  REF_REQ          out  1       refresh pending, arbiter must grant
//  REF_ACK          in   1       grant; valid only while REF_REQ=1
//  REF_BUSY         out  1       controller owns command bus for refresh
//  CKE              out  1       clock enable
//  CS_N,RAS_N,CAS_N,WE_N out 1 each  SDRAM command
//  A                out  ROW_W   address;  BS  out  BANK_W  bank select
// BEHAVIOUR
//  Reset: CKE=0, CS_N/RAS_N/CAS_N/WE_N=1 (DESELECT), A=0, BS=0, SDRAM_INIT_DONE=0,
//   REF_REQ=0, REF_BUSY=0, pending=0, timers=0. All outputs registered.
//  Cmds {CS,RAS,CAS,WE}: NOP 0111, PRE 0010 (A[10]=1), AREF 0001, LMR 0000.
//  Cycle 0 = first posedge after RST_N release: CKE=1, NOP from then on.
//  FSM: PWRUP -> PRE -> TRP -> AREF -> TRFC (loop INIT_REF_NUM) -> LMR -> TMRD -> IDLE
//   -> RPRE -> RTRP -> RAREF -> RTRFC -> IDLE. Wait states drive NOP.
//  PRE at cycle T_POWERUP_CYC; AREF k at PRE+T_RP_CYC+k*T_RFC_CYC;
//   LMR T_RFC_CYC after last AREF; SDRAM_INIT_DONE=1 T_MRD_CYC after LMR.
//  LMR: BS=0, A[ROW_W-1:10]=0, A9=0, A8:7=0, A6:4=CAS_LAT, A3=0, A2:0=BL_CODE.
//  Refresh timer starts on SDRAM_INIT_DONE; wraps at REF_PERIOD_CYC-1; each wrap
//   pending+1, saturating at 8 (further ticks dropped).
//  REF_REQ=1 while pending>0 and FSM in IDLE. REF_ACK sampled with REF_REQ=1:
//   next cycle REF_REQ=0, REF_BUSY=1, PRE-all; AREF T_RP_CYC later. REF_BUSY
//   drops when RTRFC ends (T_RFC_CYC after AREF); pending-1 on that same cycle.
//   REF_REQ re-asserts the next cycle if pending still >0.
//  REF_ACK while REF_REQ=0 is ignored. REF_REQ holds while ACK stays low.
//  Timer tick on same cycle as completion decrement: pending unchanged.
//  Async reset mid-sequence: immediate return to reset values; full init reruns.
// CONFIGURATION
//  SDRAM_REF_CNT_EN defined: extra port REF_CNT out 16, counts post-init
//   AUTO REFRESH cmds, wraps at 16'hFFFF->0, reset 0.
//  SDRAM_REF_CNT_EN undefined: no REF_CNT port and no counter logic.
//   All other behaviour identical.
// TESTING (bench params: T_POWERUP_US=1, others default)
//  1 Release reset -> CKE=1 at cycle 0; PRE A=13'h0400 at cycle 100; AREFs at cycles
//    102,109,...,151; LMR A=13'h0033 BS=0 at cycle 158; SDRAM_INIT_DONE=1 at cycle 160.
//  2 REF_ACK tied 1 -> REF_REQ rises 780 cycles after done; PRE next cycle; AREF 2 later;
//    REF_BUSY=0 and REF_REQ=0 7 cycles after AREF; sdr model reports no violation.
//  3 REF_ACK held 0 for 10 periods -> pending saturates 8; ACK=1 -> exactly 8
//    PRE+AREF pairs back to back, then REF_REQ=0.
//  4 RST_N pulsed low between 3rd and 4th init AREF -> DESELECT, CKE=0 at once;
//    on release, PRE again at cycle 100, done at 160.
//  5 Timer wrap on same cycle as RTRFC end with pending=2 -> pending stays 2.
//  6 SDRAM_REF_CNT_EN: after test 3, REF_CNT=8; preset 16'hFFFF + one refresh -> 0.

Source files
------------

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up init sequencer and postponable auto-refresh engine (up to 8 pending).
// Optional macro SDRAM_REF_CNT_EN adds REF_CNT, a count of post-init AUTO REFRESH commands.
module sdram_init_refresh_ctrl #(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int T_POWERUP_US   = 200,
  parameter int T_RP_CYC       = 2,
  parameter int T_RFC_CYC      = 7,
  parameter int T_MRD_CYC      = 2,
  parameter int INIT_REF_NUM   = 8,
  parameter int REF_PERIOD_CYC = 780,
  parameter int CAS_LAT        = 3,
  parameter int BL_CODE        = 3,
  parameter int ROW_W          = 13,
  parameter int BANK_W         = 2
) (
  input  logic              REF_CLK,
  input  logic              RST_N,
  output logic              SDRAM_INIT_DONE,
  output logic              REF_REQ,
  input  logic              REF_ACK,
  output logic              REF_BUSY,
  output logic              CKE,
  output logic              CS_N,
  output logic              RAS_N,
  output logic              CAS_N,
  output logic              WE_N,
  output logic [ROW_W-1:0]  A,
  output logic [BANK_W-1:0] BS
`ifdef SDRAM_REF_CNT_EN
  ,
  output logic [15:0]       REF_CNT
`endif
);

  localparam int T_POWERUP_CYC = CLK_FREQ_MHZ * T_POWERUP_US;
  localparam int TW = $clog2(T_POWERUP_CYC + T_RP_CYC + T_RFC_CYC + T_MRD_CYC + 1);
  localparam int RW = $clog2(REF_PERIOD_CYC + 1);
  localparam int CW = $clog2(INIT_REF_NUM + 1);

  localparam logic [3:0] S_PWRUP = 4'd0;
  localparam logic [3:0] S_PRE   = 4'd1;
  localparam logic [3:0] S_TRP   = 4'd2;
  localparam logic [3:0] S_AREF  = 4'd3;
  localparam logic [3:0] S_TRFC  = 4'd4;
  localparam logic [3:0] S_LMR   = 4'd5;
  localparam logic [3:0] S_TMRD  = 4'd6;
  localparam logic [3:0] S_IDLE  = 4'd7;
  localparam logic [3:0] S_RPRE  = 4'd8;
  localparam logic [3:0] S_RTRP  = 4'd9;
  localparam logic [3:0] S_RAREF = 4'd10;
  localparam logic [3:0] S_RTRFC = 4'd11;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_DESL = 4'b1111;

  logic [3:0]        r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [CW-1:0]     r_init_cnt, w_init_cnt_nxt;
  logic [RW-1:0]     r_rtimer;
  logic [3:0]        r_pend, w_pend_nxt;
  logic [3:0]        r_cmd, w_cmd_nxt;
  logic [ROW_W-1:0]  r_a, w_a_nxt;
  logic              r_cke, r_done, r_req, r_busy;
  logic              w_tick, w_dec, w_req_nxt, w_busy_nxt;

  // r_state names what the command bus carries during the current cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer + 1'b1;
    w_init_cnt_nxt = r_init_cnt;
    w_dec          = 1'b0;
    case (r_state)
      S_PWRUP: if (r_timer == TW'(T_POWERUP_CYC)) begin
        w_state_nxt = S_PRE;
        w_timer_nxt = '0;
      end
      S_PRE, S_TRP: begin
        w_state_nxt = S_TRP;
        if (r_timer == TW'(T_RP_CYC - 1)) begin
          w_state_nxt    = S_AREF;
          w_timer_nxt    = '0;
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      S_AREF, S_TRFC: begin
        w_state_nxt = S_TRFC;
        if (r_timer == TW'(T_RFC_CYC - 1)) begin
          w_timer_nxt = '0;
          if (r_init_cnt == CW'(INIT_REF_NUM)) begin
            w_state_nxt = S_LMR;
          end else begin
            w_state_nxt    = S_AREF;
            w_init_cnt_nxt = r_init_cnt + 1'b1;
          end
        end
      end
      S_LMR, S_TMRD: begin
        w_state_nxt = S_TMRD;
        if (r_timer == TW'(T_MRD_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end
      end
      S_IDLE: begin
        w_timer_nxt = '0;
        if (r_req && REF_ACK) w_state_nxt = S_RPRE;
      end
      S_RPRE, S_RTRP: begin
        w_state_nxt = S_RTRP;
        if (r_timer == TW'(T_RP_CYC - 1)) begin
          w_state_nxt = S_RAREF;
          w_timer_nxt = '0;
        end
      end
      S_RAREF, S_RTRFC: begin
        w_state_nxt = S_RTRFC;
        if (r_timer == TW'(T_RFC_CYC - 1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_dec       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_PWRUP;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_cmd_nxt = CMD_NOP;
    w_a_nxt   = '0;
    case (w_state_nxt)
      S_PRE, S_RPRE: begin
        w_cmd_nxt   = CMD_PRE;
        w_a_nxt[10] = 1'b1;
      end
      S_AREF, S_RAREF: w_cmd_nxt = CMD_AREF;
      S_LMR: begin
        w_cmd_nxt    = CMD_LMR;
        w_a_nxt[6:4] = 3'(CAS_LAT);
        w_a_nxt[2:0] = 3'(BL_CODE);
      end
      default: w_cmd_nxt = CMD_NOP;
    endcase
  end

  // A tick landing on the completion cycle cancels the decrement.
  assign w_tick = r_done && (r_rtimer == RW'(REF_PERIOD_CYC - 1));

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_tick && !w_dec && (r_pend != 4'd8)) w_pend_nxt = r_pend + 1'b1;
    else if (w_dec && !w_tick)                w_pend_nxt = r_pend - 1'b1;
  end

  assign w_req_nxt  = (r_state == S_IDLE) && (w_state_nxt == S_IDLE) && (w_pend_nxt != 4'd0);
  assign w_busy_nxt = (w_state_nxt == S_RPRE) || (w_state_nxt == S_RTRP) ||
                      (w_state_nxt == S_RAREF) || (w_state_nxt == S_RTRFC);

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_PWRUP;
      r_timer    <= '0;
      r_init_cnt <= '0;
      r_rtimer   <= '0;
      r_pend     <= '0;
      r_cmd      <= CMD_DESL;
      r_a        <= '0;
      r_cke      <= 1'b0;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_cmd      <= w_cmd_nxt;
      r_a        <= w_a_nxt;
      r_cke      <= 1'b1;
      r_done     <= r_done || (w_state_nxt == S_IDLE);
      r_req      <= w_req_nxt;
      r_busy     <= w_busy_nxt;
      if (r_done) r_rtimer <= w_tick ? '0 : r_rtimer + 1'b1;
    end
  end

`ifdef SDRAM_REF_CNT_EN
  logic [15:0] r_ref_cnt;
  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N)                      r_ref_cnt <= '0;
    else if (w_state_nxt == S_RAREF) r_ref_cnt <= r_ref_cnt + 1'b1;
  end
  assign REF_CNT = r_ref_cnt;
`endif

  assign SDRAM_INIT_DONE = r_done;
  assign REF_REQ         = r_req;
  assign REF_BUSY        = r_busy;
  assign CKE             = r_cke;
  assign CS_N            = r_cmd[3];
  assign RAS_N           = r_cmd[2];
  assign CAS_N           = r_cmd[1];
  assign WE_N            = r_cmd[0];
  assign A               = r_a;
  assign BS              = '0;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for sdram_init_refresh_ctrl with a 1 us power-up wait (100 cycles).
module tb_sdram_init_refresh_ctrl;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;
  localparam logic [3:0] DESL = 4'b1111;

  logic        ref_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic        ref_ack = 1'b0;
  logic        sdram_init_done, ref_req, ref_busy, cke, cs_n, ras_n, cas_n, we_n;
  logic [12:0] a;
  logic [1:0]  bs;
  logic [3:0]  cmd;
`ifdef SDRAM_REF_CNT_EN
  logic [15:0] ref_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = -1;

  sdram_init_refresh_ctrl #(.T_POWERUP_US(1)) dut (
    .REF_CLK(ref_clk), .RST_N(rst_n), .SDRAM_INIT_DONE(sdram_init_done),
    .REF_REQ(ref_req), .REF_ACK(ref_ack), .REF_BUSY(ref_busy), .CKE(cke),
    .CS_N(cs_n), .RAS_N(ras_n), .CAS_N(cas_n), .WE_N(we_n), .A(a), .BS(bs)
`ifdef SDRAM_REF_CNT_EN
    , .REF_CNT(ref_cnt)
`endif
  );

  assign cmd = {cs_n, ras_n, cas_n, we_n};

  always #5 ref_clk = ~ref_clk;

  // cyc is the index of the most recent posedge since reset release (0 = first).
  always @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (cke !== 1'b0) begin failures++; $display("FAIL reset_cke got=%b exp=0", cke); end
    checks++; if (cmd !== DESL) begin failures++; $display("FAIL reset_cmd got=%b exp=%b", cmd, DESL); end
    checks++; if (a !== 13'h0 || bs !== 2'b0) begin failures++; $display("FAIL reset_addr got=%h/%h exp=0/0", a, bs); end
    checks++; if ({sdram_init_done, ref_req, ref_busy} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {sdram_init_done, ref_req, ref_busy});
    end
  endtask

  task automatic test_init();
    logic [3:0] exp_cmd;
    logic       exp_done;
    ref_ack = 1'b0;
    rst_n   = 1'b0;
    @(negedge ref_clk);
    @(negedge ref_clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 162; c++) begin
      step();
      exp_cmd = NOP;
      if (c == 100) exp_cmd = PRE;
      if (c >= 102 && c <= 151 && ((c - 102) % 7) == 0) exp_cmd = AREF;
      if (c == 158) exp_cmd = LMR;
      exp_done = (c >= 160);
      checks++; if (cmd !== exp_cmd) begin failures++; $display("FAIL init_cmd cyc=%0d got=%b exp=%b", c, cmd, exp_cmd); end
      checks++; if (cke !== 1'b1) begin failures++; $display("FAIL init_cke cyc=%0d got=%b exp=1", c, cke); end
      checks++; if (sdram_init_done !== exp_done) begin
        failures++; $display("FAIL init_done cyc=%0d got=%b exp=%b", c, sdram_init_done, exp_done);
      end
      checks++; if (ref_req !== 1'b0 || ref_busy !== 1'b0) begin
        failures++; $display("FAIL init_req_busy cyc=%0d got=%b%b exp=00", c, ref_req, ref_busy);
      end
      if (c == 100) begin
        checks++; if (a !== 13'h0400) begin failures++; $display("FAIL init_pre_addr got=%h exp=0400", a); end
      end
      if (c == 158) begin
        checks++; if (a !== 13'h0033 || bs !== 2'b00) begin
          failures++; $display("FAIL init_lmr_addr got=%h/%h exp=0033/0", a, bs);
        end
      end
    end
  endtask

  task automatic test_refresh_single();
    logic [3:0] exp_cmd;
    logic       exp_req, exp_busy;
    ref_ack = 1'b1;
    while (cyc < 960) begin
      step();
      exp_cmd  = (cyc == 941) ? PRE : (cyc == 943) ? AREF : NOP;
      exp_req  = (cyc == 940);
      exp_busy = (cyc >= 941 && cyc <= 949);
      checks++; if (cmd !== exp_cmd) begin failures++; $display("FAIL ref1_cmd cyc=%0d got=%b exp=%b", cyc, cmd, exp_cmd); end
      checks++; if (ref_req !== exp_req) begin failures++; $display("FAIL ref1_req cyc=%0d got=%b exp=%b", cyc, ref_req, exp_req); end
      checks++; if (ref_busy !== exp_busy) begin failures++; $display("FAIL ref1_busy cyc=%0d got=%b exp=%b", cyc, ref_busy, exp_busy); end
      if (cyc == 941) begin
        checks++; if (a !== 13'h0400) begin failures++; $display("FAIL ref1_pre_addr got=%h exp=0400", a); end
      end
    end
    ref_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    ref_ack = 1'b0;
    rst_n   = 1'b0;
    @(negedge ref_clk);
    rst_n = 1'b1;
    while (cyc < 119) begin
      step();
      if (cyc == 116) begin
        checks++; if (cmd !== AREF) begin failures++; $display("FAIL mid_third_aref got=%b exp=%b", cmd, AREF); end
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cke !== 1'b0 || cmd !== DESL) begin
      failures++; $display("FAIL mid_reset_bus got=%b/%b exp=0/%b", cke, cmd, DESL);
    end
    checks++; if (a !== 13'h0 || sdram_init_done !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state got=%h/%b exp=0/0", a, sdram_init_done);
    end
    test_init();
  endtask

  task automatic test_wrap_dec();
    int n_pre;
    test_init();
    while (cyc < 2490) step();
    checks++; if (ref_req !== 1'b1) begin failures++; $display("FAIL wrap_req_pending got=%b exp=1", ref_req); end
    ref_ack = 1'b1;
    n_pre   = 0;
    while (cyc < 2600) begin
      step();
      if (cmd === PRE) n_pre++;
      if (cyc == 2491 || cyc == 2502 || cyc == 2513) begin
        checks++; if (cmd !== PRE) begin failures++; $display("FAIL wrap_pre cyc=%0d got=%b exp=%b", cyc, cmd, PRE); end
      end
      if (cyc == 2493) begin
        checks++; if (cmd !== AREF) begin failures++; $display("FAIL wrap_aref got=%b exp=%b", cmd, AREF); end
      end
      if (cyc == 2500) begin
        checks++; if (ref_busy !== 1'b0 || ref_req !== 1'b0) begin
          failures++; $display("FAIL wrap_end got=%b%b exp=00", ref_busy, ref_req);
        end
      end
    end
    checks++; if (n_pre != 3) begin failures++; $display("FAIL wrap_refresh_count got=%0d exp=3", n_pre); end
    checks++; if (ref_req !== 1'b0) begin failures++; $display("FAIL wrap_req_final got=%b exp=0", ref_req); end
    ref_ack = 1'b0;
  endtask

  task automatic test_saturate();
    int n_pre, n_aref, first_pre, last_aref, n_other;
    test_init();
    while (cyc < 7965) step();
    checks++; if (ref_req !== 1'b1 || ref_busy !== 1'b0) begin
      failures++; $display("FAIL sat_waiting got=%b%b exp=10", ref_req, ref_busy);
    end
    ref_ack   = 1'b1;
    n_pre     = 0;
    n_aref    = 0;
    n_other   = 0;
    first_pre = -1;
    last_aref = -1;
    while (cyc < 8700) begin
      step();
      if (cmd === PRE) begin
        n_pre++;
        if (first_pre < 0) first_pre = cyc;
      end else if (cmd === AREF) begin
        n_aref++;
        last_aref = cyc;
      end else if (cmd !== NOP) begin
        n_other++;
      end
    end
    checks++; if (n_pre != 8) begin failures++; $display("FAIL sat_pre_count got=%0d exp=8", n_pre); end
    checks++; if (n_aref != 8) begin failures++; $display("FAIL sat_aref_count got=%0d exp=8", n_aref); end
    checks++; if (n_other != 0) begin failures++; $display("FAIL sat_bad_cmds got=%0d exp=0", n_other); end
    checks++; if (first_pre != 7966) begin failures++; $display("FAIL sat_first_pre got=%0d exp=7966", first_pre); end
    checks++; if (last_aref != 8045) begin failures++; $display("FAIL sat_last_aref got=%0d exp=8045", last_aref); end
    checks++; if (ref_req !== 1'b0 || ref_busy !== 1'b0) begin
      failures++; $display("FAIL sat_final got=%b%b exp=00", ref_req, ref_busy);
    end
  endtask

`ifdef SDRAM_REF_CNT_EN
  task automatic test_ref_cnt();
    checks++; if (ref_cnt !== 16'd8) begin failures++; $display("FAIL cnt_after_sat got=%0d exp=8", ref_cnt); end
    force dut.r_ref_cnt = 16'hFFFF;
    step();
    release dut.r_ref_cnt;
    while (cyc < 8720) step();
    checks++; if (ref_cnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_preset got=%h exp=ffff", ref_cnt); end
    while (cyc < 8750) step();
    checks++; if (ref_cnt !== 16'h0000) begin failures++; $display("FAIL cnt_wrap got=%h exp=0000", ref_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_init();
    test_refresh_single();
    test_reset_mid();
    test_wrap_dec();
    test_saturate();
`ifdef SDRAM_REF_CNT_EN
    test_ref_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
